// File: rtl/framebuffer_scanout_reader.sv
// framebuffer_scanout_reader
// Avalon-MM pipelined read master that scans one 32-bit-per-pixel frame
// out of memory in raster order and presents it as a valid/ready pixel
// stream with start-of-frame and end-of-line markers.
// Optional feature macro: FB_CHECKSUM_EN adds a rotate-XOR frame checksum.
module framebuffer_scanout_reader #(
  parameter int unsigned             ADDRESSWIDTH = 32,
  parameter int unsigned             DATAWIDTH    = 32,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = 'h0800_0000,
  parameter int unsigned             H_ACTIVE     = 640,
  parameter int unsigned             V_ACTIVE     = 480,
  parameter int unsigned             FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_read,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest,
  output logic [DATAWIDTH-1:0]    pix_data,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic                    pix_sof,
  output logic                    pix_eol
`ifdef FB_CHECKSUM_EN
  ,
  output logic [DATAWIDTH-1:0]    frame_checksum
`endif
);

  localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned RW    = $clog2(TOTAL + 1);
  localparam int unsigned XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [RW-1:0]           req_cnt_q, req_cnt_d;
  logic [CW-1:0]           pending_q, pending_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic                    last_q, last_d;
  logic [DATAWIDTH-1:0]    mem_q [FIFO_DEPTH];

  logic start_ok, credit_ok, accept, push, pop, last_req, last_pix, at_eol;

  // Handshake qualifiers shared by the FSM and the datapath.
  always_comb begin
    start_ok    = (state_q == S_IDLE) && start;
    // Outstanding requests plus buffered pixels must never exceed the FIFO,
    // so every return has a slot. While stalled this sum cannot grow, which
    // keeps master_read asserted until the slave accepts.
    credit_ok   = ({1'b0, pending_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);
    master_read = (state_q == S_READ) && credit_ok;
    accept      = master_read && !master_waitrequest;
    push        = master_readdatavalid && (state_q != S_IDLE);
    pix_valid   = (count_q != '0);
    pop         = pix_valid && pix_ready;
    last_req    = (req_cnt_q == RW'(TOTAL - 1));
    at_eol      = (x_q == XW'(H_ACTIVE - 1));
    last_pix    = at_eol && (y_q == YW'(V_ACTIVE - 1));
    busy        = (state_q != S_IDLE);
    master_address = addr_q;
    pix_data    = mem_q[rd_ptr_q];
    pix_sof     = pix_valid && (x_q == '0) && (y_q == '0);
    pix_eol     = pix_valid && at_eol;
  end

  // Next-state logic; done is asserted for the single cycle leaving DRAIN.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (accept && last_req) state_d = S_DRAIN;
      S_DRAIN: begin
        if ((pending_q == '0) && (count_q == '0) && last_q) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address/request counters, credit bookkeeping, FIFO pointers, raster position.
  always_comb begin
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    pending_d = pending_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    x_d       = x_q;
    y_d       = y_q;
    last_d    = last_q;

    if (start_ok) begin
      addr_d    = BASE_ADDR;
      req_cnt_d = '0;
      x_d       = '0;
      y_d       = '0;
      last_d    = 1'b0;
    end

    if (accept) begin
      addr_d    = addr_q + ADDRESSWIDTH'(4);
      req_cnt_d = req_cnt_q + RW'(1);
    end
    if (done) addr_d = BASE_ADDR;

    case ({accept, push})
      2'b10:   pending_d = pending_q + CW'(1);
      2'b01:   pending_d = pending_q - CW'(1);
      default: pending_d = pending_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (pop) begin
      if (last_pix) begin
        x_d    = '0;
        y_d    = '0;
        last_d = 1'b1;
      end else if (at_eol) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= BASE_ADDR;
      req_cnt_q <= '0;
      pending_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      req_cnt_q <= req_cnt_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      last_q    <= last_d;
    end
  end

  // Return-data storage; contents need no reset since count_q gates validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= master_readdata;
  end

  // The credit rule makes a return into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (count_q == CW'(FIFO_DEPTH))));

`ifdef FB_CHECKSUM_EN
  logic [DATAWIDTH-1:0] checksum_q, checksum_d;

  // Rotate-left-then-XOR accumulation over every transferred pixel.
  always_comb begin
    checksum_d = checksum_q;
    if (start_ok) checksum_d = '0;
    else if (pop) checksum_d = {checksum_q[DATAWIDTH-2:0], checksum_q[DATAWIDTH-1]} ^ pix_data;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign frame_checksum = checksum_q;
`endif

endmodule
